// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Data-memory bus between the MEM-stage access unit and the data memory.
//   dmem_req    : request, held until granted
//   dmem_we     : 1 = store, 0 = load
//   dmem_addr   : word address, [1:0] always zero
//   dmem_be     : byte enables
//   dmem_wdata  : lane-replicated store data
//   dmem_gnt    : request accepted by memory
//   dmem_rvalid : response (load data or write acknowledge)
//   dmem_rdata  : load word
// master = access unit, slave = memory.
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access unit of the pipelined RV32I core. Runs one
// request/grant/response transaction per load/store, stalls the pipeline
// until it completes, formats load data and flags faults and bus timeouts.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   MemReqM      : MEM-stage instruction is a load or store
//   MemWriteM    : 1 = store, 0 = load
//   Funct3M      : access size / sign
//   ALUResultM   : byte address
//   WriteDataM   : right-justified store data
//   ReadData     : formatted load result (registered)
//   StallM       : pipeline hold (combinational)
//   AccessFaultM : misaligned access or illegal funct3 (combinational)
//   BusErrM      : bus timeout flag, valid in the DONE cycle (registered)
//   dmem         : data-memory bus, master side
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemReqM,
   input  logic              MemWriteM,
   input  logic [2:0]        Funct3M,
   input  logic [31:0]       ALUResultM,
   input  logic [31:0]       WriteDataM,
   output logic [31:0]       ReadData,
   output logic              StallM,
   output logic              AccessFaultM,
   output logic              BusErrM,
   mem_access_unit_if.master dmem
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Last counter value before the transaction is abandoned.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [7:0]  cnt_r;
   logic [2:0]  funct3_r;
   logic [1:0]  off_r;
   logic        req_r;
   logic        we_r;
   logic [31:0] addr_r;
   logic [3:0]  be_r;
   logic [31:0] wdata_r;
   logic [31:0] rdata_r;
   logic        buserr_r;

   logic        fault_s;
   logic        accept_s;
   logic        complete_s;
   logic        expire_s;
   logic        timeout_s;

   // Misalignment or an funct3 code that has no meaning for the access type.
   function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
      logic f;
      case (f3)
         3'b000:  f = 1'b0;
         3'b001:  f = off[0];
         3'b010:  f = off[1] | off[0];
         3'b100:  f = we;
         3'b101:  f = we | off[0];
         default: f = 1'b1;
      endcase
      return f;
   endfunction

   // Select the addressed byte/half of the bus word and extend it.
   function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         2'd3:    b = w[31:24];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = w;
         3'b100:  r = {24'h00_0000, b};
         3'b101:  r = {16'h0000, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Byte enables of a store; offsets are already known to be aligned.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3)
         3'b000:  be = 4'b0001 << off;
         3'b001:  be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate store data into every lane so the memory picks it by byte enable.
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] d;
      case (f3)
         3'b000:  d = {4{wd[7:0]}};
         3'b001:  d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   assign fault_s      = access_fault(MemWriteM, Funct3M, ALUResultM[1:0]);
   assign timeout_s    = (cnt_r >= TIMEOUT_LAST);
   assign AccessFaultM = MemReqM & fault_s;
   assign StallM       = ((state_r == IDLE) & MemReqM & ~fault_s)
                       | (state_r == REQ) | (state_r == WAIT);

   assign ReadData        = rdata_r;
   assign BusErrM         = buserr_r;
   assign dmem.dmem_req   = req_r;
   assign dmem.dmem_we    = we_r;
   assign dmem.dmem_addr  = addr_r;
   assign dmem.dmem_be    = be_r;
   assign dmem.dmem_wdata = wdata_r;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and transaction strobes; a real response beats a same-cycle timeout.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      complete_s  = 1'b0;
      expire_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (MemReqM && !fault_s) begin
               accept_s    = 1'b1;
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         REQ: begin
            if (dmem.dmem_gnt && dmem.dmem_rvalid) begin
               complete_s  = 1'b1;
               state_nxt_s = DONE;
            end else if (timeout_s) begin
               expire_s    = 1'b1;
               state_nxt_s = DONE;
            end else if (dmem.dmem_gnt) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = REQ;
            end
         end
         WAIT: begin
            if (dmem.dmem_rvalid) begin
               complete_s  = 1'b1;
               state_nxt_s = DONE;
            end else if (timeout_s) begin
               expire_s    = 1'b1;
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Cycles spent in REQ+WAIT for the current transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= 8'd0;
      end else if (accept_s) begin
         cnt_r <= 8'd0;
      end else if ((state_r == REQ) || (state_r == WAIT)) begin
         cnt_r <= cnt_r + 8'd1;
      end
   end

   // Bus outputs: captured on acceptance, held stable, request dropped on grant or timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_r    <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= 32'h0000_0000;
         be_r     <= 4'b0000;
         wdata_r  <= 32'h0000_0000;
         funct3_r <= 3'b000;
         off_r    <= 2'b00;
      end else if (accept_s) begin
         req_r    <= 1'b1;
         we_r     <= MemWriteM;
         addr_r   <= {ALUResultM[31:2], 2'b00};
         be_r     <= MemWriteM ? store_be(Funct3M, ALUResultM[1:0]) : 4'b1111;
         wdata_r  <= MemWriteM ? store_wdata(Funct3M, WriteDataM) : 32'h0000_0000;
         funct3_r <= Funct3M;
         off_r    <= ALUResultM[1:0];
      end else if (((state_r == REQ) && dmem.dmem_gnt) || expire_s) begin
         req_r    <= 1'b0;
      end
   end

   // Load result and bus-error flag; stores leave ReadData untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_r  <= 32'h0000_0000;
         buserr_r <= 1'b0;
      end else if (expire_s) begin
         rdata_r  <= 32'h0000_0000;
         buserr_r <= 1'b1;
      end else if (complete_s) begin
         if (!we_r) begin
            rdata_r <= load_format(funct3_r, off_r, dmem.dmem_rdata);
         end
      end else if (state_r == DONE) begin
         buserr_r <= 1'b0;
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-memory access unit for the pipelined RV32I core. Takes the load/store request held in the EX/MEM register, runs a request/grant/response transaction on the data-memory bus, and stalls the pipeline until the transaction completes. It supplies the aligned, sign/zero-extended `ReadData` that the MEM/WB pipeline register captures. It also generates store byte enables and flags misaligned accesses, illegal accesses and bus timeouts.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent in REQ+WAIT before a bus error is declared. Legal range 1–255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemReqM`  in  1  MEM-stage instruction is a load or store.
- `MemWriteM`  in  1  1 = store, 0 = load.
- `Funct3M`  in  3  access size and sign.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store data, right-justified.
- `ReadData`  out  32  formatted load result, registered.
- `StallM`  out  1  holds PC, IF/ID, ID/EX and EX/MEM; combinational.
- `AccessFaultM`  out  1  misaligned access or illegal funct3; combinational, no bus transaction.
- `BusErrM`  out  1  timeout flag, registered; valid in DONE.
- `dmem_req`  out  1  bus request, registered.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  32  word address, with `[1:0]` = 0.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  response (load data or write acknowledge).
- `dmem_rdata`  in  32  load word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- Legal `Funct3M` values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Fault condition: misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) or illegal funct3.
- IDLE:
  - If `MemReqM` is high and there is no fault, latch addr/we/be/wdata/funct3/byte offset, go to REQ, and set `dmem_req`=1.
  - If there is a fault: `AccessFaultM`=1, `StallM`=0, stay in IDLE, no bus activity.
- REQ:
  - `dmem_req` and all bus outputs stay stable until `dmem_gnt`=1.
  - On grant: drop `dmem_req` and go to WAIT.
  - If `dmem_rvalid` arrives in the same cycle as the grant, go directly to DONE.
- WAIT:
  - On `dmem_rvalid`, go to DONE.
  - For a load, capture the formatted `dmem_rdata` into `ReadData` on that edge.
  - For a store, `ReadData` is unchanged.
- DONE: one cycle with `StallM`=0, so the pipeline advances and MEM/WB samples `ReadData`. Then go unconditionally to IDLE.
- Timeout:
  - An 8-bit counter clears when leaving IDLE and increments in REQ/WAIT.
  - On reaching `TIMEOUT`: deassert `dmem_req`, set `ReadData`=0 and `BusErrM`=1, go to DONE.
  - `BusErrM` clears on exit from DONE.
- `StallM` = (IDLE & `MemReqM` & no fault) | REQ | WAIT.
- Load formatting, where `off` = addr[1:0]:
  - LB/LBU: select byte `off`; sign-extend (LB) or zero-extend (LBU).
  - LH/LHU: select half `off[1]`; sign-extend (LH) or zero-extend (LHU).
  - LW: full word.
- Store encoding:
  - SB: `be` = 0001<<off, `wdata` = {4{byte}}.
  - SH: `be` = 0011<<off, `wdata` = {2{half}}.
  - SW: `be` = 1111.
  - Loads drive `be` = 1111 and `dmem_we` = 0.
- `dmem_rvalid` is ignored in IDLE, DONE and REQ-without-grant. Stale responses are dropped.

## Timing
- Reset (asynchronous, `reset`=0): state = IDLE; `ReadData`=0; `BusErrM`=0; `dmem_req`=0; `dmem_we`=0; `dmem_addr`=0; `dmem_be`=0; `dmem_wdata`=0; counter = 0.
- `StallM` and `AccessFaultM` follow combinationally (0 while `MemReqM`=0).
- Reset during REQ or WAIT abandons the transaction. Any later `dmem_rvalid` is ignored.
- Zero-wait memory (grant in the first REQ cycle, `rvalid` one cycle later):
  - c0 IDLE (stall)
  - c1 REQ (stall)
  - c2 WAIT (stall)
  - c3 DONE (no stall)
  - MEM stage takes 4 cycles; each extra grant or response wait cycle adds 1.
- Grant and `rvalid` in the same cycle: c0 IDLE, c1 REQ, c2 DONE (3 cycles).
- Back-to-back accesses: the next request can be accepted in the IDLE cycle right after DONE. No DONE→REQ shortcut.
- Timeout: `BusErrM` goes high in the DONE cycle, exactly `TIMEOUT` cycles after entering REQ.

## Test plan
- Reset: `reset`=0 mid-WAIT, then `rvalid`=1 after release → state IDLE, `ReadData`=0, `dmem_req`=0, response ignored.
- LB at 0x1003, `rdata`=0x80FF_7F01 → `ReadData`=0xFFFF_FF80, `be`=1111, `StallM` high for exactly 3 cycles with zero-wait memory. LBU at the same address → 0x0000_0080.
- SH at 0x2002, `WriteDataM`=0x1234_ABCD → `dmem_addr`=0x2000, `be`=1100, `wdata`=0xABCD_ABCD, `we`=1; `dmem_req` held stable through 3 cycles with `gnt`=0.
- LW at 0x3001 → `AccessFaultM`=1, `StallM`=0, no `dmem_req`. Funct3=011 → same response.
- `TIMEOUT`=4, `gnt` never asserted → `dmem_req` drops, DONE with `BusErrM`=1 and `ReadData`=0; next cycle IDLE, `BusErrM`=0.
- Grant and `rvalid` in the same cycle on LW 0x40, `rdata`=0xDEAD_BEEF → DONE on the next cycle, `ReadData`=0xDEAD_BEEF.
